// File: rtl/sum_window_accum.sv
// Windowed accumulator: sums 2**WIN_LOG2 samples, presents sum and average on valid/ready.
// Optional macro SUM_WINDOW_ROUND_EN selects a rounded, saturating average instead of truncation.
module sum_window_accum #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned WIN_LOG2 = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       ena,
   input  logic                       din_valid,
   input  logic [DATA_W-1:0]          din,
   output logic                       din_ready,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic [DATA_W+WIN_LOG2-1:0] dout_sum,
   output logic [DATA_W-1:0]          dout_avg,
   output logic                       busy
);

   localparam int unsigned SUM_W   = DATA_W + WIN_LOG2;
   localparam int unsigned CNT_W   = (WIN_LOG2 == 0) ? 1 : WIN_LOG2;
   localparam int unsigned WIN_LEN = 1 << WIN_LOG2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [SUM_W-1:0]  r_acc;
   logic [SUM_W-1:0]  w_acc_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_dout_valid;
   logic              w_dout_valid_nxt;
   logic [SUM_W-1:0]  r_dout_sum;
   logic [SUM_W-1:0]  w_dout_sum_nxt;
   logic [DATA_W-1:0] r_dout_avg;
   logic [DATA_W-1:0] w_dout_avg_nxt;
   logic              w_take;
   logic [SUM_W-1:0]  w_sum_in;
   logic [DATA_W-1:0] w_avg_in;

   assign din_ready  = (r_state != HOLD);
   assign busy       = (r_state != IDLE);
   assign dout_valid = r_dout_valid;
   assign dout_sum   = r_dout_sum;
   assign dout_avg   = r_dout_avg;

   assign w_take   = din_valid & din_ready & ena;
   // Running sum including the sample presented this cycle; a new window starts from din alone.
   assign w_sum_in = (r_state == IDLE) ? SUM_W'(din) : (r_acc + SUM_W'(din));

`ifdef SUM_WINDOW_ROUND_EN
   localparam int unsigned RND_W = SUM_W + 1;
   localparam int unsigned HALF  = (WIN_LOG2 == 0) ? 0 : (1 << (WIN_LOG2 - 1));
   logic [RND_W-1:0] w_round;
   logic [RND_W-1:0] w_round_shr;

   // Half-up rounding with saturation at the DATA_W maximum.
   assign w_round     = RND_W'(w_sum_in) + RND_W'(HALF);
   assign w_round_shr = w_round >> WIN_LOG2;
   assign w_avg_in    = (w_round_shr > RND_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}}
                                                               : w_round_shr[DATA_W-1:0];
`else
   logic [SUM_W-1:0] w_trunc_shr;

   assign w_trunc_shr = w_sum_in >> WIN_LOG2;
   assign w_avg_in    = w_trunc_shr[DATA_W-1:0];
`endif

   // State and datapath registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= IDLE;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_dout_valid <= 1'b0;
         r_dout_sum   <= '0;
         r_dout_avg   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_acc        <= w_acc_nxt;
         r_cnt        <= w_cnt_nxt;
         r_dout_valid <= w_dout_valid_nxt;
         r_dout_sum   <= w_dout_sum_nxt;
         r_dout_avg   <= w_dout_avg_nxt;
      end
   end

   // Next-state and next-value logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_acc_nxt        = r_acc;
      w_cnt_nxt        = r_cnt;
      w_dout_valid_nxt = r_dout_valid;
      w_dout_sum_nxt   = r_dout_sum;
      w_dout_avg_nxt   = r_dout_avg;

      case (r_state)
         IDLE: begin
            if (w_take) begin
               w_acc_nxt = w_sum_in;
               w_cnt_nxt = CNT_W'(1);
               if (WIN_LEN == 1) begin
                  w_dout_sum_nxt   = w_sum_in;
                  w_dout_avg_nxt   = w_avg_in;
                  w_dout_valid_nxt = 1'b1;
                  w_state_nxt      = HOLD;
               end else begin
                  w_state_nxt = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (w_take) begin
               w_acc_nxt = w_sum_in;
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(WIN_LEN - 1)) begin
                  w_dout_sum_nxt   = w_sum_in;
                  w_dout_avg_nxt   = w_avg_in;
                  w_dout_valid_nxt = 1'b1;
                  w_state_nxt      = HOLD;
               end
            end
         end
         HOLD: begin
            if (r_dout_valid && dout_ready) begin
               w_dout_valid_nxt = 1'b0;
               w_acc_nxt        = '0;
               w_cnt_nxt        = '0;
               w_state_nxt      = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sum_window_accum.sv
// Bench for sum_window_accum: directed scenarios plus random traffic against a sample-queue model.
module tb_sum_window_accum;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned WIN_LOG2 = 2;
   localparam int unsigned WIN_LEN  = 1 << WIN_LOG2;

   logic                       clk = 1'b0;
   logic                       rstn = 1'b0;
   logic                       ena = 1'b0;
   logic                       din_valid = 1'b0;
   logic [DATA_W-1:0]          din = '0;
   logic                       din_ready;
   logic                       dout_valid;
   logic                       dout_ready = 1'b0;
   logic [DATA_W+WIN_LOG2-1:0] dout_sum;
   logic [DATA_W-1:0]          dout_avg;
   logic                       busy;

   int n_cmp  = 0;
   int n_fail = 0;

   sum_window_accum #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) dut (
      .clk(clk), .rstn(rstn), .ena(ena), .din_valid(din_valid), .din(din),
      .din_ready(din_ready), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_sum(dout_sum), .dout_avg(dout_avg), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_avg(input int s);
      int a;
`ifdef SUM_WINDOW_ROUND_EN
      a = (s + ((WIN_LOG2 == 0) ? 0 : (1 << (WIN_LOG2 - 1)))) / WIN_LEN;
      if (a > 255) a = 255;
`else
      a = s / WIN_LEN;
`endif
      return a;
   endfunction

   // Model: samples collected into a queue; a full window becomes a pending result until consumed.
   int q_samples[$];
   bit m_valid;
   int m_sum;
   int m_avg;
   int m_windows = 0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q_samples.delete();
         m_valid = 1'b0;
         m_sum   = 0;
         m_avg   = 0;
      end else if (m_valid) begin
         if (dout_ready) m_valid = 1'b0;
      end else if (ena && din_valid) begin
         q_samples.push_back(int'(din));
         if (q_samples.size() == WIN_LEN) begin
            m_sum = 0;
            foreach (q_samples[k]) m_sum += q_samples[k];
            m_avg = exp_avg(m_sum);
            m_valid = 1'b1;
            m_windows++;
            q_samples.delete();
         end
      end
   end

   bit chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en && rstn) begin
         chk("din_ready", int'(din_ready), int'(!m_valid));
         chk("dout_valid", int'(dout_valid), int'(m_valid));
         chk("busy", int'(busy), int'(m_valid || q_samples.size() != 0));
         if (m_valid) begin
            chk("dout_sum", int'(dout_sum), m_sum);
            chk("dout_avg", int'(dout_avg), m_avg);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a sample and hold it until it is accepted.
   task automatic send(input int v);
      bit got;
      got = 1'b0;
      din = DATA_W'(v);
      din_valid = 1'b1;
      ena = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (din_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("send_timeout", 0, 1);
      step();
   endtask

   task automatic wait_valid();
      bit got;
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (dout_valid) begin
            got = 1'b1;
            break;
         end
         step();
      end
      if (!got) chk("valid_timeout", 0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, int'(dout_valid), 0);
      chk({tag, "_sum"}, int'(dout_sum), 0);
      chk({tag, "_avg"}, int'(dout_avg), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_ready"}, int'(din_ready), 1);
   endtask

   initial begin
      // Reset held for three cycles.
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rstn = 1'b1;
      step();
      check_reset_outputs("post_rst");
      chk_en = 1'b1;

      // Basic window.
      dout_ready = 1'b1;
      send(10); send(20); send(30); send(42);
      din_valid = 1'b0;
      chk("basic_valid", int'(dout_valid), 1);
      chk("basic_sum", int'(dout_sum), 102);
`ifdef SUM_WINDOW_ROUND_EN
      chk("basic_avg", int'(dout_avg), 26);
`else
      chk("basic_avg", int'(dout_avg), 25);
`endif
      chk("basic_model_sum", m_sum, 102);
      step();
      chk("basic_done", int'(dout_valid), 0);
      chk("basic_idle", int'(busy), 0);

      // Gaps on ena and din_valid, then backpressure in HOLD.
      send(10); send(20);
      ena = 1'b0; din_valid = 1'b1; din = 8'd99;
      repeat (2) step();
      ena = 1'b1; din_valid = 1'b0;
      step();
      dout_ready = 1'b0;
      send(30); send(42);
      chk("gap_valid", int'(dout_valid), 1);
      chk("gap_ready", int'(din_ready), 0);
      repeat (5) step();
      chk("stall_sum", int'(dout_sum), 102);
      chk("stall_valid", int'(dout_valid), 1);
      din_valid = 1'b0;
      dout_ready = 1'b1;
      step();
      chk("stall_release", int'(dout_valid), 0);

      // Max values.
      repeat (4) send(255);
      din_valid = 1'b0;
      chk("max_sum", int'(dout_sum), 1020);
      chk("max_avg", int'(dout_avg), 255);
      step();

      // Reset mid-window discards the partial sum.
      send(100); send(100);
      din_valid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_valid", int'(dout_valid), 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      step();
      repeat (4) send(1);
      din_valid = 1'b0;
      chk("midrst_sum", int'(dout_sum), 4);
      chk("midrst_avg", int'(dout_avg), 1);
      step();

      // Asynchronous reset while holding a result.
      dout_ready = 1'b0;
      send(7); send(8); send(9); send(11);
      din_valid = 1'b0;
      wait_valid();
      chk("hold_sum", int'(dout_sum), 35);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_outputs("async");
      @(negedge clk);
      rstn = 1'b1;
      step();

      // Back-to-back windows with din_valid held high.
      dout_ready = 1'b1;
      for (int v = 1; v <= 8; v++) begin
         send(v);
         if (v == 4) chk("b2b_sum0", int'(dout_sum), 10);
         if (v == 8) chk("b2b_sum1", int'(dout_sum), 26);
      end
      din_valid = 1'b0;
      repeat (2) step();

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         ena        = ($urandom_range(0, 3) != 0);
         din_valid  = ($urandom_range(0, 3) != 0);
         din        = DATA_W'($urandom);
         dout_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      din_valid = 1'b0;
      dout_ready = 1'b1;
      repeat (3) step();
      if (m_windows < 20) chk("rand_windows", m_windows, 20);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
